// File: rtl/regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w_sb
// Purpose  : Register file with one write port, two combinational read ports,
//            an optional write-to-read bypass, an optional hard-wired zero R0,
//            and a per-register pending (scoreboard) bit. A register can be
//            reserved until its result is written back.
// Ports    : clk, reset         - rising-edge clock, async active-high reset
//            data_in, writenum,
//            write              - write port
//            readnum_a/b,
//            data_out_a/b       - combinational read ports
//            reserve, reservenum- set a pending bit on the next edge
//            pending_a/b        - pending bit of the register at readnum_a/b
//            pending_mask       - registered pending bit of every register
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w_sb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter bit BYPASS  = 1'b0,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    input  logic             reserve,
    input  logic [AW-1:0]    reservenum,
    output logic             pending_a,
    output logic             pending_b,
    output logic [DEPTH-1:0] pending_mask
);

    // One extra bit so DEPTH=2**AW is representable for range compares.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // An index is usable when it names a real register and is not the
    // hard-wired zero register.
    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_rd_a_ok;
    logic w_rd_b_ok;
    logic w_byp_a;
    logic w_byp_b;

    assign w_wr_ok   = ({1'b0, writenum} < c_DEPTH) &&
                       !(ZERO_R0 && (writenum == '0));
    assign w_rsv_ok  = ({1'b0, reservenum} < c_DEPTH) &&
                       !(ZERO_R0 && (reservenum == '0));
    assign w_rd_a_ok = ({1'b0, readnum_a} < c_DEPTH) &&
                       !(ZERO_R0 && (readnum_a == '0));
    assign w_rd_b_ok = ({1'b0, readnum_b} < c_DEPTH) &&
                       !(ZERO_R0 && (readnum_b == '0));

    assign w_byp_a = BYPASS && write && w_wr_ok && (writenum == readnum_a);
    assign w_byp_b = BYPASS && write && w_wr_ok && (writenum == readnum_b);

    // Next-state: the reservation is applied after the write so that a
    // same-index write+reserve leaves the register pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (write && w_wr_ok) begin
            regs_d[writenum] = data_in;
            pend_d[writenum] = 1'b0;
        end
        if (reserve && w_rsv_ok) begin
            pend_d[reservenum] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Read port A. A forwarded write also reports "not pending", since the
    // value being presented is the writeback itself.
    always_comb begin
        data_out_a = '0;
        pending_a  = 1'b0;
        if (w_rd_a_ok) begin
            if (w_byp_a) begin
                data_out_a = data_in;
            end else begin
                data_out_a = regs_q[readnum_a];
                pending_a  = pend_q[readnum_a];
            end
        end
    end

    // Read port B, identical to port A.
    always_comb begin
        data_out_b = '0;
        pending_b  = 1'b0;
        if (w_rd_b_ok) begin
            if (w_byp_b) begin
                data_out_b = data_in;
            end else begin
                data_out_b = regs_q[readnum_b];
                pending_b  = pend_q[readnum_b];
            end
        end
    end

    assign pending_mask = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r1w_sb
// Purpose  : Self-checking bench for regfile_2r1w_sb. Three instances share
//            one stimulus: u0 (defaults), u1 (BYPASS=1, ZERO_R0=1) and
//            u2 (DEPTH=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [2:0]  writenum, readnum_a, readnum_b, reservenum;
    logic        write, reserve;

    logic [15:0] a0, b0, a1, b1, a2, b2;
    logic        pa0, pb0, pa1, pb1, pa2, pb2;
    logic [7:0]  m0, m1;
    logic [5:0]  m2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sb u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(a0), .data_out_b(b0), .reserve(reserve),
        .reservenum(reservenum), .pending_a(pa0), .pending_b(pb0),
        .pending_mask(m0));

    regfile_2r1w_sb #(.BYPASS(1'b1), .ZERO_R0(1'b1)) u1 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(a1), .data_out_b(b1), .reserve(reserve),
        .reservenum(reservenum), .pending_a(pa1), .pending_b(pb1),
        .pending_mask(m1));

    regfile_2r1w_sb #(.DEPTH(6)) u2 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(a2), .data_out_b(b2), .reserve(reserve),
        .reservenum(reservenum), .pending_a(pa2), .pending_b(pb2),
        .pending_mask(m2));

    typedef struct {
        logic        we;
        logic [2:0]  wn;
        logic [15:0] din;
        logic        rv;
        logic [2:0]  rn;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        epa;
        logic        epb;
        logic [7:0]  em;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0; reserve = 1'b0;
        writenum = '0; reservenum = '0; data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        readnum_a = '0; readnum_b = '0;

        // Vectors for u0 (DEPTH=8, no bypass); outputs checked after the edge.
        //          we   wn    din       rv   rn    ra    rb    ea        eb        pa   pb   mask
        vecs[0] = '{1'b0,3'd0,16'hA5A5,1'b0,3'd0,3'd0,3'd0,16'h0000,16'h0000,1'b0,1'b0,8'h00};
        vecs[1] = '{1'b1,3'd1,16'h5A5A,1'b0,3'd0,3'd1,3'd3,16'h5A5A,16'h0000,1'b0,1'b0,8'h00};
        vecs[2] = '{1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,3'd1,16'h0000,16'h5A5A,1'b1,1'b0,8'h04};
        vecs[3] = '{1'b1,3'd2,16'h1234,1'b0,3'd0,3'd2,3'd2,16'h1234,16'h1234,1'b0,1'b0,8'h00};
        vecs[4] = '{1'b1,3'd4,16'hBEEF,1'b1,3'd4,3'd4,3'd2,16'hBEEF,16'h1234,1'b1,1'b0,8'h10};
        vecs[5] = '{1'b1,3'd5,16'h1111,1'b1,3'd6,3'd5,3'd6,16'h1111,16'h0000,1'b0,1'b1,8'h50};
        vecs[6] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,3'd7,3'd0,16'h0000,16'h0000,1'b0,1'b0,8'h50};
        vecs[7] = '{1'b1,3'd7,16'h7777,1'b1,3'd4,3'd7,3'd4,16'h7777,16'hBEEF,1'b0,1'b1,8'h50};
        vecs[8] = '{1'b1,3'd4,16'h4444,1'b0,3'd0,3'd4,3'd6,16'h4444,16'h0000,1'b0,1'b1,8'h40};
        vecs[9] = '{1'b1,3'd0,16'h0F0F,1'b0,3'd0,3'd0,3'd1,16'h0F0F,16'h5A5A,1'b0,1'b0,8'h40};

        // Reset state: every index reads 0 on both ports, nothing pending.
        #12;
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            #1;
            chk($sformatf("reset_rd%0d", i), {a0, b0, pa0, pb0, m0},
                {16'h0, 16'h0, 1'b0, 1'b0, 8'h00});
        end
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            write = vecs[v].we; writenum = vecs[v].wn; data_in = vecs[v].din;
            reserve = vecs[v].rv; reservenum = vecs[v].rn;
            readnum_a = vecs[v].ra; readnum_b = vecs[v].rb;
            tick();
            chk($sformatf("vec%0d", v), {a0, b0, pa0, pb0, m0},
                {vecs[v].ea, vecs[v].eb, vecs[v].epa, vecs[v].epb, vecs[v].em});
            idle();
        end

        // Bypass / zero-register sequence.
        do_reset();
        @(negedge clk);
        write = 1'b1; writenum = 3'd3; data_in = 16'hCAFE;
        readnum_a = 3'd3; readnum_b = 3'd3;
        #1;
        chk("byp_fwd_a", {a1, pa1}, {16'hCAFE, 1'b0});
        chk("byp_fwd_b", b1, 16'hCAFE);
        chk("nobyp_pre_edge", a0, 16'h0000);
        tick();
        chk("byp_stored", {a1, a0}, {16'hCAFE, 16'hCAFE});
        write = 1'b0; reserve = 1'b1; reservenum = 3'd3;
        tick();
        chk("byp_reserved", {pa1, m1}, {1'b1, 8'h08});
        reserve = 1'b0;
        write = 1'b1; data_in = 16'hD00D;
        #1;
        chk("byp_clears_pend", {a1, pa1}, {16'hD00D, 1'b0});
        chk("nobyp_still_pend", {a0, pa0}, {16'hCAFE, 1'b1});
        tick();
        chk("pend_clear_after_edge", {pa0, m0, pa1, m1},
            {1'b0, 8'h00, 1'b0, 8'h00});
        writenum = 3'd0; data_in = 16'hFFFF; reserve = 1'b1; reservenum = 3'd0;
        readnum_a = 3'd0;
        #1;
        chk("r0_no_fwd", {a1, pa1}, {16'h0000, 1'b0});
        tick();
        chk("r0_dropped", {a1, pa1, m1}, {16'h0000, 1'b0, 8'h00});
        chk("r0_normal_wr_rsv", {a0, pa0, m0}, {16'hFFFF, 1'b1, 8'h01});
        idle();

        // DEPTH=6: out-of-range index, then asynchronous mid-cycle reset.
        do_reset();
        @(negedge clk);
        write = 1'b1; writenum = 3'd7; data_in = 16'h7777;
        reserve = 1'b1; reservenum = 3'd7;
        readnum_a = 3'd7; readnum_b = 3'd6;
        tick();
        chk("oor_ignored", {a2, b2, pa2, pb2, m2},
            {16'h0, 16'h0, 1'b0, 1'b0, 6'h00});
        chk("oor_ref_u0", {a0, pa0}, {16'h7777, 1'b1});
        reserve = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            writenum = 3'(r); data_in = 16'h1000 + 16'(r);
            tick();
        end
        write = 1'b0;
        readnum_a = 3'd5; readnum_b = 3'd1;
        #1;
        chk("fill_r5_r1", {a2, b2}, {16'h1005, 16'h1001});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_u2", {a2, b2, pa2, pb2, m2},
            {16'h0, 16'h0, 1'b0, 1'b0, 6'h00});
        chk("async_reset_u0", {a0, b0, m0}, {16'h0, 16'h0, 8'h00});
        write = 1'b1; writenum = 3'd1; data_in = 16'hABCD;
        tick();
        chk("reset_overrides_write", b2, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("still_zero_after_release", b2, 16'h0000);
        tick();
        chk("first_write_after_reset", {b2, b0}, {16'hABCD, 16'hABCD});
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
